midi_msg_rx: RTL and testbench

Parametrised MIDI input receiver: oversampled serial byte capture, MIDI message assembly with running status, and a small message FIFO with a valid/ready output. It sits between the MIDI input pin and the synth/control logic in the baud_clk domain. It adds framing-error detection, per-status message lengths, real-time message interleaving and back-pressure.

---
 rtl/midi_pkg.sv | 55 +++++
 rtl/midi_uart_rx.sv | 103 ++++++++++
 rtl/midi_msg_rx.sv | 179 +++++++++++++++++
 tb/tb_midi_msg_rx.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared types and helpers for the MIDI input receiver.
//   midi_msg_t     - one assembled message {status, data1, data2, len}
//   len_info_t     - number of data bytes a status expects, plus a drop flag
//   rx_state_t     - byte receiver FSM states
//   midi_data_len  - status byte -> len_info_t lookup
//   ST_*           - status byte range boundaries
package midi_pkg;

  localparam logic [7:0] ST_CHAN_LO = 8'h80;  // first channel status
  localparam logic [7:0] ST_CHAN_HI = 8'hEF;  // last channel status
  localparam logic [7:0] ST_SYS_LO  = 8'hF0;  // first system common
  localparam logic [7:0] ST_RT_LO   = 8'hF8;  // first real-time

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [1:0] len;
  } midi_msg_t;

  typedef struct packed {
    logic [1:0] len;
    logic       drop;
  } len_info_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Data bytes expected after a status byte. Sysex and undefined system
  // common codes report drop=1: their data bytes must be discarded.
  function automatic len_info_t midi_data_len(input logic [7:0] status);
    len_info_t r;
    r.len  = 2'd0;
    r.drop = 1'b0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: r.len = 2'd2;
      4'hC, 4'hD:                   r.len = 2'd1;
      4'hF: begin
        case (status)
          8'hF2:                      r.len  = 2'd2;
          8'hF1, 8'hF3:               r.len  = 2'd1;
          8'hF0, 8'hF4, 8'hF5, 8'hF7: r.drop = 1'b1;
          default:                    r.len  = 2'd0;
        endcase
      end
      default: r.len = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 2-flop synchroniser plus oversampled 8N1 byte receiver.
//   baud_clk     - clock, OVERSAMPLE ticks per bit
//   rst          - asynchronous, active-low reset
//   rx_i         - raw serial input, idle high
//   byte_o       - received byte (valid while byte_valid_o is high)
//   byte_valid_o - one-cycle pulse: stop bit sampled high
//   frame_err_o  - one-cycle pulse: stop bit sampled low, byte discarded
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  // Synchroniser resets to the idle (high) line level.
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rx_i};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      // Re-check the start bit mid-bit; a high here was only a glitch.
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // From the mid-start point, every OVERSAMPLE ticks lands mid-bit.
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) byte_valid_o = 1'b1;
          else      frame_err_o  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/midi_msg_rx.sv
// midi_msg_rx: MIDI input receiver. Captures serial bytes, assembles MIDI
// messages (running status, real-time interleaving, sysex dropping) and
// queues them in a small FIFO with a valid/ready output.
//   baud_clk   - clock, OVERSAMPLE ticks per bit
//   rst        - asynchronous, active-low reset
//   midi_rx    - raw serial input, idle high
//   msg_valid  - FIFO head holds a message
//   msg_ready  - consumer accepts the head when msg_valid is high
//   msg_status, msg_data1, msg_data2, msg_len - head entry, 0 when empty
//   frame_err  - one-cycle pulse on a low stop bit
//   overflow   - one-cycle pulse when a completed message is dropped
//   fifo_level - occupied FIFO entries
// Handshake: an entry leaves the FIFO on each rising edge where msg_valid
// and msg_ready are both high; msg_valid never depends on msg_ready.
module midi_msg_rx
  import midi_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        baud_clk,
  input  logic                        rst,
  input  logic                        midi_rx,
  output logic                        msg_valid,
  input  logic                        msg_ready,
  output logic [7:0]                  msg_status,
  output logic [7:0]                  msg_data1,
  output logic [7:0]                  msg_data2,
  output logic [1:0]                  msg_len,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_frame_err;

  midi_uart_rx #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_uart (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .rx_i        (midi_rx),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_byte_valid),
    .frame_err_o (rx_frame_err)
  );

  // ---------------------------------------------------------------------
  // Parser. cur_active_q means "data bytes are being collected for
  // cur_status_q". It is cleared both when there is no running status and
  // in sysex/undefined drop mode, so both cases ignore data bytes alike.
  // cur_sticky_q marks a channel status that survives message completion.
  // ---------------------------------------------------------------------
  logic [7:0] cur_status_q, cur_status_d;
  logic       cur_active_q, cur_active_d;
  logic       cur_sticky_q, cur_sticky_d;
  logic [1:0] need_q, need_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] d1_q, d1_d;
  logic       push_q, push_d;
  midi_msg_t  push_msg_q, push_msg_d;
  len_info_t  info;

  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      cur_status_q <= 8'h00;
      cur_active_q <= 1'b0;
      cur_sticky_q <= 1'b0;
      need_q       <= 2'd0;
      cnt_q        <= 2'd0;
      d1_q         <= 8'h00;
      push_q       <= 1'b0;
      push_msg_q   <= '0;
    end else begin
      cur_status_q <= cur_status_d;
      cur_active_q <= cur_active_d;
      cur_sticky_q <= cur_sticky_d;
      need_q       <= need_d;
      cnt_q        <= cnt_d;
      d1_q         <= d1_d;
      push_q       <= push_d;
      push_msg_q   <= push_msg_d;
    end
  end

  always_comb begin
    cur_status_d = cur_status_q;
    cur_active_d = cur_active_q;
    cur_sticky_d = cur_sticky_q;
    need_d       = need_q;
    cnt_d        = cnt_q;
    d1_d         = d1_q;
    push_d       = 1'b0;
    push_msg_d   = push_msg_q;
    info         = midi_data_len(rx_byte);
    if (rx_frame_err) begin
      cnt_d = 2'd0;
    end else if (rx_byte_valid) begin
      if (rx_byte >= ST_RT_LO) begin
        // Real-time: emitted at once, parser state untouched.
        push_d     = 1'b1;
        push_msg_d = '{status: rx_byte, data1: 8'h00, data2: 8'h00, len: 2'd0};
      end else if (rx_byte >= ST_CHAN_LO) begin
        cur_status_d = rx_byte;
        need_d       = info.len;
        cnt_d        = 2'd0;
        cur_sticky_d = (rx_byte <= ST_CHAN_HI);
        cur_active_d = !info.drop && (info.len != 2'd0);
        // A zero-length non-drop status (F6) is a complete message by itself.
        if (!info.drop && info.len == 2'd0) begin
          push_d     = 1'b1;
          push_msg_d = '{status: rx_byte, data1: 8'h00, data2: 8'h00, len: 2'd0};
        end
      end else if (cur_active_q) begin
        if (cnt_q + 2'd1 == need_q) begin
          push_d            = 1'b1;
          push_msg_d.status = cur_status_q;
          push_msg_d.data1  = (cnt_q == 2'd0) ? rx_byte : d1_q;
          push_msg_d.data2  = (need_q == 2'd2) ? rx_byte : 8'h00;
          push_msg_d.len    = need_q;
          cnt_d             = 2'd0;
          if (!cur_sticky_q) cur_active_d = 1'b0;
        end else begin
          d1_d  = rx_byte;
          cnt_d = cnt_q + 2'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Message FIFO. Pointers carry one extra bit so full and empty differ.
  // ---------------------------------------------------------------------
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] level;
  midi_msg_t   mem_q [FIFO_DEPTH];
  midi_msg_t   head;
  logic        pop, full, wr_en;
  logic        overflow_q;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == DEPTH_L);
  assign msg_valid = (level != '0);
  assign pop       = msg_valid && msg_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign wr_en     = push_q && (!full || pop);

  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      overflow_q <= push_q && full && !pop;
    end
  end

  // Storage needs no reset: outputs are forced to 0 while empty.
  always_ff @(posedge baud_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_msg_q;
  end

  assign head       = msg_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign msg_status = head.status;
  assign msg_data1  = head.data1;
  assign msg_data2  = head.data2;
  assign msg_len    = head.len;
  assign frame_err  = rx_frame_err;
  assign overflow   = overflow_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_midi_msg_rx.sv
module tb_midi_msg_rx;

  localparam int OS    = 8;
  localparam int DEPTH = 4;

  logic       baud_clk = 1'b0;
  logic       rst;
  logic       midi_rx;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status, msg_data1, msg_data2;
  logic [1:0] msg_len;
  logic       frame_err, overflow;
  logic [$clog2(DEPTH):0] fifo_level;

  midi_msg_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .baud_clk  (baud_clk),
    .rst       (rst),
    .midi_rx   (midi_rx),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_status(msg_status),
    .msg_data1 (msg_data1),
    .msg_data2 (msg_data2),
    .msg_len   (msg_len),
    .frame_err (frame_err),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  // ---------------- clock / reset ----------------
  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_ferr   = 0;
  int n_ovf    = 0;
  int first_valid_cyc = -1;
  int stop_cyc = 0;
  bit rand_ready_en = 1'b0;

  // Accepted messages and pulses, sampled away from the active edge.
  always @(negedge baud_clk) begin
    if (rst === 1'b1) begin
      if (msg_valid && msg_ready) got_q.push_back({msg_status, msg_data1, msg_data2, msg_len});
      if (frame_err) n_ferr++;
      if (overflow) n_ovf++;
      if (msg_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end
  end

  always @(posedge baud_clk) begin
    #1;
    if (rand_ready_en) msg_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- reference model ----------------
  // Message-level view: a status names what it expects, data bytes are
  // queued until that many have arrived.
  logic [7:0] m_status;
  bit         m_collect;
  bit         m_keep;
  int         m_need;
  logic [7:0] m_data[$];
  int         m_bad_stops;

  function automatic int spec_len(input logic [7:0] s);
    if (s >= 8'h80 && s <= 8'hBF) return 2;
    if (s >= 8'hE0 && s <= 8'hEF) return 2;
    if (s >= 8'hC0 && s <= 8'hDF) return 1;
    if (s == 8'hF2) return 2;
    if (s == 8'hF1 || s == 8'hF3) return 1;
    if (s == 8'hF6) return 0;
    return -1;  // sysex / undefined: drop
  endfunction

  function automatic void model_reset();
    m_collect = 1'b0;
    m_keep = 1'b0;
    m_need = 0;
    m_status = 8'h00;
    m_data.delete();
    m_bad_stops = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'hF8) begin
      exp_q.push_back({b, 16'h0000, 2'd0});
    end else if (b >= 8'h80) begin
      m_data.delete();
      m_status  = b;
      m_need    = spec_len(b);
      m_keep    = (b < 8'hF0);
      m_collect = (m_need > 0);
      if (m_need == 0) exp_q.push_back({b, 16'h0000, 2'd0});
    end else if (m_collect) begin
      m_data.push_back(b);
      if (m_data.size() == m_need) begin
        exp_q.push_back({m_status, m_data[0], (m_need == 2) ? m_data[1] : 8'h00, 2'(m_need)});
        m_data.delete();
        if (!m_keep) m_collect = 1'b0;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    midi_rx = 1'b0;
    repeat (OS) tick();
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (OS) tick();
    end
    stop_cyc = cyc;
    if (good_stop) begin
      midi_rx = 1'b1;
      repeat (OS) tick();
    end else begin
      // Low long enough to cover the stop sample, then back to idle.
      midi_rx = 1'b0;
      repeat (OS / 2 + 1) tick();
      midi_rx = 1'b1;
      repeat (OS / 2 - 1) tick();
    end
    repeat (OS) tick();
  endtask

  task automatic settle();
    repeat (4 * OS) tick();
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    n_ferr = 0;
    n_ovf = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    midi_rx = 1'b1;
    msg_ready = 1'b0;
    repeat (3) tick();
    midi_rx = 1'b0;  // activity during reset must be ignored
    repeat (3) tick();
    n_checks++;
    if (msg_valid !== 1'b0) $display("FAIL reset_valid: got %b need 0", msg_valid); else n_pass++;
    n_checks++;
    if ({msg_status, msg_data1, msg_data2, msg_len} !== 26'd0)
      $display("FAIL reset_msg: got %h need 0", {msg_status, msg_data1, msg_data2, msg_len});
    else n_pass++;
    n_checks++;
    if (fifo_level !== '0) $display("FAIL reset_level: got %0d need 0", fifo_level); else n_pass++;
    n_checks++;
    if ({frame_err, overflow} !== 2'b00) $display("FAIL reset_pulses: got %b need 00", {frame_err, overflow}); else n_pass++;
    midi_rx = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (4 * OS) tick();
    n_checks++;
    if (msg_valid !== 1'b0 || fifo_level !== '0)
      $display("FAIL post_reset_idle: got valid=%b level=%0d need 0/0", msg_valid, fifo_level);
    else n_pass++;
  endtask

  task automatic test_note_on();
    clear_sb();
    msg_ready = 1'b1;
    exp_q.push_back({8'h90, 8'h3C, 8'h64, 2'd2});
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    first_valid_cyc = -1;
    send_byte(8'h64, 1'b1);
    settle();
    n_checks++;
    if (first_valid_cyc - stop_cyc < OS / 2 + 3 || first_valid_cyc - stop_cyc > OS / 2 + 5)
      $display("FAIL note_latency: got %0d cycles from stop bit start, need %0d..%0d",
               first_valid_cyc - stop_cyc, OS / 2 + 3, OS / 2 + 5);
    else n_pass++;
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL note_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL note_msg%0d: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_running_status();
    logic [7:0] seq [5] = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h50};
    clear_sb();
    exp_q.push_back({8'h90, 8'h3C, 8'h64, 2'd2});
    exp_q.push_back({8'h90, 8'h3E, 8'h50, 2'd2});
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL running_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL running_msg%0d: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_realtime();
    logic [7:0] seq [6] = '{8'hC5, 8'h07, 8'h90, 8'hF8, 8'h3C, 8'h64};
    clear_sb();
    exp_q.push_back({8'hC5, 8'h07, 8'h00, 2'd1});
    exp_q.push_back({8'hF8, 8'h00, 8'h00, 2'd0});
    exp_q.push_back({8'h90, 8'h3C, 8'h64, 2'd2});
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL realtime_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL realtime_msg%0d: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_sysex();
    logic [7:0] seq [5] = '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h40};
    clear_sb();
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    settle();
    n_checks++;
    if (got_q.size() != 0) $display("FAIL sysex_count: got %0d need 0", got_q.size()); else n_pass++;
  endtask

  task automatic test_frame_err();
    clear_sb();
    send_byte(8'h90, 1'b0);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    settle();
    n_checks++;
    if (n_ferr != 1) $display("FAIL ferr_pulses: got %0d need 1", n_ferr); else n_pass++;
    n_checks++;
    if (got_q.size() != 0) $display("FAIL ferr_count: got %0d need 0", got_q.size()); else n_pass++;
  endtask

  task automatic test_overflow();
    clear_sb();
    msg_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send_byte(8'hC0, 1'b1);
      send_byte(8'(i), 1'b1);
      if (i <= DEPTH) exp_q.push_back({8'hC0, 8'(i), 8'h00, 2'd1});
    end
    settle();
    n_checks++;
    if (fifo_level !== ($clog2(DEPTH) + 1)'(DEPTH)) $display("FAIL ovf_level: got %0d need %0d", fifo_level, DEPTH); else n_pass++;
    n_checks++;
    if (n_ovf != 1) $display("FAIL ovf_pulses: got %0d need 1", n_ovf); else n_pass++;
    n_checks++;
    if (msg_status !== 8'hC0 || msg_data1 !== 8'h01) $display("FAIL ovf_head: got %h %h need c0 01", msg_status, msg_data1); else n_pass++;
    msg_ready = 1'b1;
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL ovf_drain_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL ovf_msg%0d: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++;
    if (fifo_level !== '0 || msg_valid !== 1'b0) $display("FAIL ovf_empty: got level=%0d valid=%b need 0/0", fifo_level, msg_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    clear_sb();
    msg_ready = 1'b0;
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    // Third byte interrupted by reset just before its stop bit.
    b = 8'h64;
    midi_rx = 1'b0;
    repeat (OS) tick();
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (OS) tick();
    end
    midi_rx = 1'b1;
    #3 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2 * OS) tick();
    n_checks++;
    if (msg_valid !== 1'b0 || fifo_level !== '0) $display("FAIL midreset_push: got valid=%b level=%0d need 0/0", msg_valid, fifo_level); else n_pass++;
    // Running status was lost with the reset.
    msg_ready = 1'b1;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    exp_q.push_back({8'h80, 8'h40, 8'h00, 2'd2});
    send_byte(8'h80, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL midreset_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL midreset_msg%0d: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit good;
    for (int r = 0; r < 3; r++) begin
      clear_sb();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      model_reset();
      rand_ready_en = 1'b1;
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 9))
          0, 1:    b = 8'h80 + 8'($urandom_range(0, 8'h6F));
          2:       b = 8'hF0 + 8'($urandom_range(0, 7));
          3:       b = 8'hF8 + 8'($urandom_range(0, 7));
          default: b = 8'($urandom_range(0, 127));
        endcase
        good = ($urandom_range(0, 15) != 0);
        if (good) model_byte(b);
        else begin
          m_data.delete();
          m_bad_stops++;
        end
        send_byte(b, good);
      end
      rand_ready_en = 1'b0;
      msg_ready = 1'b1;
      settle();
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d need %0d", r, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rand%0d_msg%0d: got %h need %h", r, i, got_q[i], exp_q[i]); else n_pass++;
      end
      n_checks++;
      if (n_ferr != m_bad_stops) $display("FAIL rand%0d_ferr: got %0d need %0d", r, n_ferr, m_bad_stops); else n_pass++;
      n_checks++;
      if (n_ovf != 0) $display("FAIL rand%0d_ovf: got %0d need 0", r, n_ovf); else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_sysex();
    test_frame_err();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
